// File: rtl/alu_issue_wb.sv
// Issue/writeback shell around an external combinational ALU.
// Instructions enter over valid/ready, read operands from an internal register
// file (with forwarding from the EX and WB stages), drive the ALU from the EX
// register and retire through a WB register that streams downstream. The
// register file is written when a legal result is accepted downstream.
module alu_issue_wb #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     resetn,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_op,
    input  logic [$clog2(NREGS)-1:0] in_rd,
    input  logic [$clog2(NREGS)-1:0] in_rs1,
    input  logic [$clog2(NREGS)-1:0] in_rs2,
    input  logic                     in_use_imm,
    input  logic [WIDTH-1:0]         in_imm,

    output logic [WIDTH-1:0]         alu_rs1,
    output logic [WIDTH-1:0]         alu_rs2,
    output logic [3:0]               alu_op,
    output logic                     alu_clr,
    input  logic [WIDTH-1:0]         alu_rd,
    input  logic [2:0]               alu_flag,

    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [$clog2(NREGS)-1:0] wb_rd_idx,
    output logic [WIDTH-1:0]         wb_data,
    output logic [2:0]               wb_flag,

    output logic [2:0]               flag_sticky,
    input  logic                     flag_clr,
    output logic [CNT_W-1:0]         illegal_cnt
);

    localparam int IDX_W = $clog2(NREGS);

    localparam logic [3:0]       OP_FIRST_LEGAL = 4'd1;
    localparam logic [3:0]       OP_LAST_LEGAL  = 4'd12;
    localparam logic [2:0]       FLAG_ILLEGAL   = 3'b100;
    localparam logic [CNT_W-1:0] CNT_MAX        = '1;

    // EX stage registers
    logic             exValid_q,   exValid_d;
    logic             exIllegal_q, exIllegal_d;
    logic [IDX_W-1:0] exRd_q,      exRd_d;
    logic [WIDTH-1:0] exOpnd1_q,   exOpnd1_d;
    logic [WIDTH-1:0] exOpnd2_q,   exOpnd2_d;
    logic [3:0]       exOp_q,      exOp_d;

    // WB stage registers
    logic             wbValid_q,   wbValid_d;
    logic             wbIllegal_q, wbIllegal_d;
    logic [IDX_W-1:0] wbRdIdx_q,   wbRdIdx_d;
    logic [WIDTH-1:0] wbData_q,    wbData_d;
    logic [2:0]       wbFlag_q,    wbFlag_d;

    // Architectural state
    logic [WIDTH-1:0] rf_q [NREGS];
    logic [2:0]       flagSticky_q, flagSticky_d;
    logic [CNT_W-1:0] illegalCnt_q, illegalCnt_d;

    // Pipeline control
    logic             wbAdv;
    logic             exAdv;
    logic             accept;
    logic             wbFire;
    logic             rfWe;
    logic             exFwdOk;
    logic             wbFwdOk;
    logic             opIllegal;

    // Operand values selected at accept time
    logic [WIDTH-1:0] rs1Val;
    logic [WIDTH-1:0] rs2Val;
    logic [WIDTH-1:0] opnd2Val;

    // Handshake and advance terms; a stage may move when the stage after it frees up.
    always_comb begin
        wbAdv     = !wbValid_q || wb_ready;
        exAdv     = !exValid_q || wbAdv;
        accept    = in_valid && exAdv;
        wbFire    = wbValid_q && wb_ready;
        rfWe      = wbFire && !wbIllegal_q;
        exFwdOk   = exValid_q && !exIllegal_q;
        wbFwdOk   = wbValid_q && !wbIllegal_q;
        opIllegal = (in_op < OP_FIRST_LEGAL) || (in_op > OP_LAST_LEGAL);
    end

    // Operand select: youngest in-flight producer wins (EX, then WB, then register file).
    always_comb begin
        rs1Val = rf_q[in_rs1];
        if (exFwdOk && (exRd_q == in_rs1)) begin
            rs1Val = alu_rd;
        end else if (wbFwdOk && (wbRdIdx_q == in_rs1)) begin
            rs1Val = wbData_q;
        end

        rs2Val = rf_q[in_rs2];
        if (exFwdOk && (exRd_q == in_rs2)) begin
            rs2Val = alu_rd;
        end else if (wbFwdOk && (wbRdIdx_q == in_rs2)) begin
            rs2Val = wbData_q;
        end

        opnd2Val = in_use_imm ? in_imm : rs2Val;
    end

    // EX next state: refill on every advance, capture operands only on an accepted op.
    always_comb begin
        exValid_d   = exValid_q;
        exIllegal_d = exIllegal_q;
        exRd_d      = exRd_q;
        exOpnd1_d   = exOpnd1_q;
        exOpnd2_d   = exOpnd2_q;
        exOp_d      = exOp_q;

        if (exAdv) begin
            exValid_d = in_valid;
        end

        if (accept) begin
            exIllegal_d = opIllegal;
            exRd_d      = in_rd;
            exOpnd1_d   = rs1Val;
            exOpnd2_d   = opnd2Val;
            exOp_d      = in_op;
        end
    end

    // WB next state: capture the ALU result when EX moves down; illegal ops never carry ALU output.
    always_comb begin
        wbValid_d   = wbValid_q;
        wbIllegal_d = wbIllegal_q;
        wbRdIdx_d   = wbRdIdx_q;
        wbData_d    = wbData_q;
        wbFlag_d    = wbFlag_q;

        if (wbAdv) begin
            wbValid_d = exValid_q;
        end

        if (wbAdv && exValid_q) begin
            wbIllegal_d = exIllegal_q;
            wbRdIdx_d   = exRd_q;
            wbData_d    = exIllegal_q ? '0 : alu_rd;
            wbFlag_d    = exIllegal_q ? FLAG_ILLEGAL : alu_flag;
        end
    end

    // Sticky flags and the saturating illegal-op counter, both updated on the WB handshake.
    always_comb begin
        flagSticky_d = flag_clr ? 3'b000 : flagSticky_q;
        illegalCnt_d = illegalCnt_q;

        if (wbFire) begin
            flagSticky_d = flagSticky_d | wbFlag_q;
            if (wbIllegal_q && (illegalCnt_q != CNT_MAX)) begin
                illegalCnt_d = illegalCnt_q + CNT_W'(1);
            end
        end
    end

    // Pipeline and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            exValid_q    <= 1'b0;
            exIllegal_q  <= 1'b0;
            exRd_q       <= '0;
            exOpnd1_q    <= '0;
            exOpnd2_q    <= '0;
            exOp_q       <= '0;
            wbValid_q    <= 1'b0;
            wbIllegal_q  <= 1'b0;
            wbRdIdx_q    <= '0;
            wbData_q     <= '0;
            wbFlag_q     <= '0;
            flagSticky_q <= '0;
            illegalCnt_q <= '0;
        end else begin
            exValid_q    <= exValid_d;
            exIllegal_q  <= exIllegal_d;
            exRd_q       <= exRd_d;
            exOpnd1_q    <= exOpnd1_d;
            exOpnd2_q    <= exOpnd2_d;
            exOp_q       <= exOp_d;
            wbValid_q    <= wbValid_d;
            wbIllegal_q  <= wbIllegal_d;
            wbRdIdx_q    <= wbRdIdx_d;
            wbData_q     <= wbData_d;
            wbFlag_q     <= wbFlag_d;
            flagSticky_q <= flagSticky_d;
            illegalCnt_q <= illegalCnt_d;
        end
    end

    // Register file: cleared on reset, written only by legal results leaving WB.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rfWe) begin
            rf_q[wbRdIdx_q] <= wbData_q;
        end
    end

    assign in_ready    = exAdv;

    assign alu_rs1     = exOpnd1_q;
    assign alu_rs2     = exOpnd2_q;
    assign alu_op      = exOp_q;
    assign alu_clr     = !exValid_q;

    assign wb_valid    = wbValid_q;
    assign wb_rd_idx   = wbRdIdx_q;
    assign wb_data     = wbData_q;
    assign wb_flag     = wbFlag_q;

    assign flag_sticky = flagSticky_q;
    assign illegal_cnt = illegalCnt_q;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Testbench for alu_issue_wb: behavioural ALU, architectural reference model
// and a scoreboard that checks every retired result in program order.
module tb_alu_issue_wb;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd4;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
        logic [2:0]  flag;
        bit          illegal;
        int          acceptCycle;
        bit          chkLat;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs1;
    logic [2:0]  in_rs2;
    logic        in_use_imm;
    logic [15:0] in_imm;
    logic [15:0] alu_rs1;
    logic [15:0] alu_rs2;
    logic [3:0]  alu_op;
    logic        alu_clr;
    logic [15:0] alu_rd;
    logic [2:0]  alu_flag;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_rd_idx;
    logic [15:0] wb_data;
    logic [2:0]  wb_flag;
    logic [2:0]  flag_sticky;
    logic        flag_clr;
    logic [7:0]  illegal_cnt;

    int          checkCount = 0;
    int          failCount  = 0;
    int          cycle      = 0;
    int          acceptCount = 0;

    exp_t        expQ[$];
    logic [15:0] retData[$];
    logic [2:0]  retFlag[$];
    logic [15:0] refRf[8];
    logic [2:0]  expSticky;
    logic [7:0]  expCnt;
    bit          modelOn   = 1'b0;
    bit          prevStall = 1'b0;
    logic [21:0] prevWb;
    bit          checkLat  = 1'b0;
    bit          randReady = 1'b0;
    logic        readyFixed = 1'b1;

    exp_t        mEntry;
    exp_t        pEntry;
    logic [2:0]  hsFlag;
    logic [18:0] refOut;
    logic [15:0] refA;
    logic [15:0] refB;
    logic [18:0] aluOut;

    alu_issue_wb #(.WIDTH(16), .NREGS(8), .CNT_W(8)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_use_imm  (in_use_imm),
        .in_imm      (in_imm),
        .alu_rs1     (alu_rs1),
        .alu_rs2     (alu_rs2),
        .alu_op      (alu_op),
        .alu_clr     (alu_clr),
        .alu_rd      (alu_rd),
        .alu_flag    (alu_flag),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd_idx   (wb_rd_idx),
        .wb_data     (wb_data),
        .wb_flag     (wb_flag),
        .flag_sticky (flag_sticky),
        .flag_clr    (flag_clr),
        .illegal_cnt (illegal_cnt)
    );

    // Behavioural ALU: returns {flag, result}; flags are {illegal, carry, borrow/slt}.
    function automatic logic [18:0] aluFn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic [2:0]  f;
        r = '0;
        f = '0;
        s = '0;
        case (op)
            4'd1:  begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; f[1] = s[16]; end
            4'd2:  begin r = a - b; f[0] = (a < b); end
            4'd3:  r = a & b;
            4'd4:  r = a | b;
            4'd5:  r = a ^ b;
            4'd6:  r = a << b[3:0];
            4'd7:  r = a >> b[3:0];
            4'd8:  r = $signed(a) >>> b[3:0];
            4'd9:  begin f[0] = ($signed(a) < $signed(b)); r = {15'd0, f[0]}; end
            4'd10: r = {{8{a[7]}}, a[7:0]};
            4'd11: r = {8'd0, a[7:0]};
            4'd12: r = 16'd0 - a;
            default: f[2] = 1'b1;
        endcase
        return {f, r};
    endfunction

    // Combinational ALU seen by the DUT; held at zero while alu_clr is high.
    always_comb begin
        aluOut = aluFn(alu_op, alu_rs1, alu_rs2);
        if (alu_clr) aluOut = '0;
    end
    assign alu_rd   = aluOut[15:0];
    assign alu_flag = aluOut[18:16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic checkRetired(input string name, input int idx, input logic [15:0] expData, input logic [2:0] expFlag);
        if (idx >= retData.size()) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL %s: result %0d never retired, expected data 0x%0h", name, idx, expData);
        end else begin
            checkOutput({name, "_data"}, 32'(retData[idx]), 32'(expData));
            checkOutput({name, "_flag"}, 32'(retFlag[idx]), 32'(expFlag));
        end
    endtask

    // Scoreboard and reference model: pushes expectations at accept, pops and compares at retire.
    always @(negedge clk) begin
        if (!resetn) begin
            expQ.delete();
            for (int i = 0; i < 8; i++) refRf[i] = '0;
            expSticky = '0;
            expCnt    = '0;
            prevStall = 1'b0;
            modelOn   = 1'b1;
        end else if (modelOn) begin
            checkOutput("in_ready", 32'(in_ready), 32'((expQ.size() < 2) || wb_ready));
            checkOutput("flag_sticky", 32'(flag_sticky), 32'(expSticky));
            checkOutput("illegal_cnt", 32'(illegal_cnt), 32'(expCnt));
            if (prevStall) begin
                checkOutput("wb_hold_valid", 32'(wb_valid), 32'd1);
                checkOutput("wb_hold_payload", 32'({wb_rd_idx, wb_flag, wb_data}), 32'(prevWb));
            end
            hsFlag = '0;
            if (wb_valid && wb_ready) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected_retire: got rd=%0d data=0x%0h, expected nothing outstanding", wb_rd_idx, wb_data);
                end else begin
                    mEntry = expQ.pop_front();
                    checkOutput("wb_rd_idx", 32'(wb_rd_idx), 32'(mEntry.rd));
                    checkOutput("wb_data", 32'(wb_data), 32'(mEntry.data));
                    checkOutput("wb_flag", 32'(wb_flag), 32'(mEntry.flag));
                    if (mEntry.chkLat) checkOutput("latency", 32'(cycle + 1 - mEntry.acceptCycle), 32'd2);
                    retData.push_back(wb_data);
                    retFlag.push_back(wb_flag);
                    hsFlag = mEntry.flag;
                    if (mEntry.illegal && expCnt != 8'hFF) expCnt = expCnt + 8'd1;
                end
            end
            expSticky = (flag_clr ? 3'b000 : expSticky) | hsFlag;
            prevStall = wb_valid && !wb_ready;
            prevWb    = {wb_rd_idx, wb_flag, wb_data};
            if (in_valid && in_ready) begin
                refA   = refRf[in_rs1];
                refB   = in_use_imm ? in_imm : refRf[in_rs2];
                refOut = aluFn(in_op, refA, refB);
                pEntry.rd          = in_rd;
                pEntry.illegal     = (in_op == 4'd0) || (in_op > 4'd12);
                pEntry.data        = pEntry.illegal ? 16'd0 : refOut[15:0];
                pEntry.flag        = pEntry.illegal ? 3'b100 : refOut[18:16];
                pEntry.acceptCycle = cycle + 1;
                pEntry.chkLat      = checkLat;
                if (!pEntry.illegal) refRf[in_rd] = refOut[15:0];
                expQ.push_back(pEntry);
                acceptCount++;
            end
        end
    end

    // Downstream ready: either a fixed level or random backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            wb_ready = randReady ? ($urandom_range(0, 3) != 0) : readyFixed;
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setReady(input logic v);
        readyFixed = v;
        wb_ready   = v;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                 input logic [2:0] rs2, input logic useImm, input logic [15:0] imm);
        int  n;
        logic ok;
        in_valid   = 1'b1;
        in_op      = op;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_imm = useImm;
        in_imm     = imm;
        n  = 0;
        ok = 1'b0;
        do begin
            @(negedge clk);
            ok = in_ready;
            nextCycle();
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || wb_valid) && n < 300) begin
            nextCycle();
            n++;
        end
        if (n >= 300) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL drain_timeout: got %0d results outstanding, expected 0", expQ.size());
        end
        @(negedge clk);
    endtask

    initial begin
        automatic logic [3:0] illOps[4] = '{4'd0, 4'd13, 4'd14, 4'd15};
        int base;
        int accBase;
        logic [3:0]  rOp;
        logic [15:0] rImm;

        resetn     = 1'b0;
        in_valid   = 1'b0;
        in_op      = '0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_use_imm = 1'b0;
        in_imm     = '0;
        flag_clr   = 1'b0;
        wb_ready   = 1'b1;

        $display("[TB] reset");
        repeat (2) nextCycle();
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("t1_in_ready", 32'(in_ready), 32'd1);
        checkOutput("t1_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("t1_flag_sticky", 32'(flag_sticky), 32'd0);
        checkOutput("t1_illegal_cnt", 32'(illegal_cnt), 32'd0);
        nextCycle();
        base = retData.size();
        applyStimulus(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0);
        drain();
        checkRetired("t1_add", base, 16'h0000, 3'b000);

        $display("[TB] back-to-back forwarding");
        nextCycle();
        base = retData.size();
        checkLat = 1'b1;
        applyStimulus(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5);
        applyStimulus(OP_ADD, 3'd2, 3'd1, 3'd1, 1'b0, 16'd0);
        applyStimulus(OP_ADD, 3'd4, 3'd2, 3'd1, 1'b0, 16'd0);
        checkLat = 1'b0;
        drain();
        checkRetired("t2_r1", base,     16'd5,  3'b000);
        checkRetired("t2_r2", base + 1, 16'd10, 3'b000);
        checkRetired("t2_r4", base + 2, 16'd15, 3'b000);

        $display("[TB] borrow and sticky clear");
        nextCycle();
        base = retData.size();
        applyStimulus(OP_SUB, 3'd5, 3'd0, 3'd0, 1'b1, 16'd1);
        drain();
        checkRetired("t3_sub", base, 16'hFFFF, 3'b001);
        checkOutput("t3_sticky_set", 32'(flag_sticky), 32'd1);
        nextCycle();
        flag_clr = 1'b1;
        nextCycle();
        flag_clr = 1'b0;
        @(negedge clk);
        checkOutput("t3_sticky_clr", 32'(flag_sticky), 32'd0);

        $display("[TB] backpressure");
        nextCycle();
        setReady(1'b0);
        nextCycle();
        base    = retData.size();
        accBase = acceptCount;
        applyStimulus(OP_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 16'd1);
        applyStimulus(OP_ADD, 3'd7, 3'd0, 3'd0, 1'b1, 16'd2);
        in_valid   = 1'b1;
        in_op      = OP_SUB;
        in_rd      = 3'd6;
        in_rs1     = 3'd7;
        in_rs2     = 3'd6;
        in_use_imm = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t4_accepted", 32'(acceptCount - accBase), 32'd2);
        checkOutput("t4_in_ready_low", 32'(in_ready), 32'd0);
        nextCycle();
        setReady(1'b1);
        applyStimulus(OP_SUB, 3'd6, 3'd7, 3'd6, 1'b0, 16'd0);
        applyStimulus(OP_ADD, 3'd7, 3'd6, 3'd7, 1'b0, 16'd0);
        drain();
        checkOutput("t4_retired", 32'(retData.size() - base), 32'd4);
        checkRetired("t4_op0", base,     16'd1, 3'b000);
        checkRetired("t4_op1", base + 1, 16'd2, 3'b000);
        checkRetired("t4_op2", base + 2, 16'd1, 3'b000);
        checkRetired("t4_op3", base + 3, 16'd3, 3'b000);

        $display("[TB] random traffic");
        nextCycle();
        randReady = 1'b1;
        for (int k = 0; k < 300; k++) begin
            rOp  = 4'($urandom_range(0, 15));
            rImm = 16'($urandom);
            flag_clr = ($urandom_range(0, 15) == 0);
            applyStimulus(rOp, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rImm);
            if ($urandom_range(0, 3) == 0) begin
                flag_clr = 1'b0;
                nextCycle();
            end
        end
        flag_clr  = 1'b0;
        randReady = 1'b0;
        setReady(1'b1);
        drain();

        $display("[TB] mid-operation reset");
        nextCycle();
        setReady(1'b0);
        applyStimulus(OP_ADD, 3'd3, 3'd3, 3'd0, 1'b1, 16'd1);
        applyStimulus(OP_ADD, 3'd4, 3'd4, 3'd0, 1'b1, 16'd2);
        resetn = 1'b0;
        setReady(1'b1);
        nextCycle();
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("t6_wb_valid", 32'(wb_valid), 32'd0);
        nextCycle();
        base = retData.size();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(OP_ADD, 3'(i), 3'(i), 3'd0, 1'b1, 16'd0);
        end
        drain();
        for (int i = 0; i < 8; i++) begin
            checkRetired("t6_rf_zero", base + i, 16'd0, 3'b000);
        end

        $display("[TB] illegal ops");
        nextCycle();
        base = retData.size();
        applyStimulus(OP_OR, 3'd1, 3'd0, 3'd0, 1'b1, 16'd7);
        applyStimulus(4'hF, 3'd1, 3'd1, 3'd1, 1'b0, 16'd0);
        applyStimulus(OP_ADD, 3'd6, 3'd1, 3'd0, 1'b1, 16'd0);
        drain();
        checkRetired("t5_r1_set", base,     16'd7, 3'b000);
        checkRetired("t5_illegal", base + 1, 16'd0, 3'b100);
        checkRetired("t5_r1_kept", base + 2, 16'd7, 3'b000);
        checkOutput("t5_cnt_one", 32'(illegal_cnt), 32'd1);
        nextCycle();
        for (int k = 0; k < 254; k++) begin
            applyStimulus(illOps[k % 4], 3'(k % 8), 3'd0, 3'd0, 1'b0, 16'd0);
        end
        drain();
        checkOutput("t5_cnt_max", 32'(illegal_cnt), 32'd255);
        nextCycle();
        applyStimulus(4'hF, 3'd2, 3'd0, 3'd0, 1'b0, 16'd0);
        drain();
        checkOutput("t5_cnt_saturated", 32'(illegal_cnt), 32'd255);

        repeat (2) nextCycle();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

    // Global time limit so a stuck design cannot hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
